// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg
// Shared definitions for the conv stream sequencer: the sequencer state
// encoding and the weight-count helper that sizes a full conv weight set
// (kernel taps + per-output bias + MACC coefficient + layer scale).
package conv_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } seq_state_e;

  function automatic int unsigned calc_num_wt(input int unsigned k0,
                                              input int unsigned k1,
                                              input int unsigned in_ch,
                                              input int unsigned out_ch);
    return k0 * k1 * in_ch * out_ch + out_ch + 2;
  endfunction

endpackage

// File: rtl/conv_seq_prefetch.sv
// conv_seq_prefetch
// One-entry pixel buffer sitting between a 1-cycle-latency pixel memory and
// the conv input port.
//
// Handshake: a transfer happens at a rising edge where the buffer holds a
// pixel, fifo_rd_en=1 and fifo_almost_full=0. The transferred pixel appears
// on o_data with o_valid=1 in the following cycle; without a transfer o_valid
// is 0 and o_data keeps its last value. Both outputs are registered, so there
// is no combinational path from the flow-control inputs to o_valid.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_allow            upstream permits a new pixel read (pixels remain)
//   src_px_data         pixel memory read data (valid the cycle after a read)
//   fifo_rd_en          conv is ready to accept a pixel
//   fifo_almost_full    conv input fifo is nearly full; blocks transfers
//   rd_issue            a pixel memory read is launched at this edge
//   xfer                a pixel is handed to conv at this edge
//   o_data, o_valid     registered pixel stream to conv
module conv_seq_prefetch #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_allow,
  input  logic [DW-1:0] src_px_data,
  input  logic          fifo_rd_en,
  input  logic          fifo_almost_full,
  output logic          rd_issue,
  output logic          xfer,
  output logic [DW-1:0] o_data,
  output logic          o_valid
);

  // The single entry lives either "in flight" (read issued last edge, data
  // currently on src_px_data) or in hold_data once it has waited a cycle.
  // Reads are only launched when the entry is free or leaving, so the two
  // flags are never set together.
  logic          inflight;
  logic          hold_valid;
  logic [DW-1:0] hold_data;
  logic          buf_valid;
  logic [DW-1:0] buf_data;

  assign buf_valid = inflight | hold_valid;
  assign buf_data  = inflight ? src_px_data : hold_data;
  assign xfer      = buf_valid & fifo_rd_en & ~fifo_almost_full;
  assign rd_issue  = rd_allow & (~buf_valid | xfer);

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
    end else begin
      inflight <= rd_issue;
      if (xfer) begin
        hold_valid <= 1'b0;
      end else if (inflight) begin
        hold_valid <= 1'b1;
        hold_data  <= src_px_data;
      end
      o_valid <= xfer;
      if (xfer) begin
        o_data <= buf_data;
      end
    end
  end

endmodule

// File: rtl/conv_stream_sequencer.sv
// conv_stream_sequencer
// Loads a complete conv weight set from a local weight memory, then streams
// frame_count frames of pixels from a pixel memory into conv, honouring the
// fifo_rd_en / fifo_almost_full flow control.
//
// Optional feature: define CONV_SEQ_WT_CHECKSUM_EN to build a running 32-bit
// sum of all written weights on wt_checksum; otherwise wt_checksum is 0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, frame_count            begin request (IDLE only), frames to stream
//   busy, done                    activity flag, one-cycle completion pulse
//   src_wt_addr, src_wt_data      weight memory read port (1-cycle latency)
//   src_px_addr, src_px_data      pixel memory read port (1-cycle latency)
//   weight_wr_data/addr/en        weight write port into conv
//   o_data, o_valid               pixel stream into conv i_data/i_valid
//   fifo_rd_en, fifo_almost_full  flow control from conv
//   wt_checksum                   sum of written weights (optional)
//   dbg_state                     current sequencer state
import conv_seq_pkg::*;

module conv_stream_sequencer #(
  parameter int unsigned IN_WIDTH     = 4,
  parameter int unsigned IN_HEIGHT    = 4,
  parameter int unsigned IN_CHANNEL   = 2,
  parameter int unsigned OUT_CHANNEL  = 2,
  parameter int unsigned KERNEL_0     = 3,
  parameter int unsigned KERNEL_1     = 3,
  parameter int unsigned WT_BASE_ADDR = 0,
  parameter int unsigned PX_AW        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             frame_count,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             src_wt_addr,
  input  logic [31:0]             src_wt_data,
  output logic [PX_AW-1:0]        src_px_addr,
  input  logic [8*IN_CHANNEL-1:0] src_px_data,
  output logic [31:0]             weight_wr_data,
  output logic [31:0]             weight_wr_addr,
  output logic                    weight_wr_en,
  output logic [8*IN_CHANNEL-1:0] o_data,
  output logic                    o_valid,
  input  logic                    fifo_rd_en,
  input  logic                    fifo_almost_full,
  output logic [31:0]             wt_checksum,
  output logic [1:0]              dbg_state
);

  localparam int unsigned NUM_WT   = calc_num_wt(KERNEL_0, KERNEL_1, IN_CHANNEL, OUT_CHANNEL);
  localparam int unsigned FRAME_PX = IN_WIDTH * IN_HEIGHT;

  seq_state_e  state;
  logic [15:0] fc_r;
  logic [31:0] wcnt;   // weights written so far
  logic [31:0] pcnt;   // pixel reads issued so far
  logic [31:0] xcnt;   // pixels transferred so far
  logic [31:0] npx;
  logic        done_r;
  logic        rd_allow;
  logic        rd_issue;
  logic        xfer;

  assign npx       = 32'(fc_r) * 32'(FRAME_PX);
  assign rd_allow  = (state == STREAM) && (pcnt < npx);
  assign done      = done_r;
  // done is registered off FINISH, so busy is held through the pulse cycle.
  assign busy      = (state != IDLE) || done_r;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      fc_r           <= '0;
      wcnt           <= '0;
      pcnt           <= '0;
      xcnt           <= '0;
      done_r         <= 1'b0;
      src_wt_addr    <= '0;
      src_px_addr    <= '0;
      weight_wr_en   <= 1'b0;
      weight_wr_addr <= '0;
      weight_wr_data <= '0;
    end else begin
      done_r       <= 1'b0;
      weight_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          // src_wt_addr rests at 0 in IDLE, so word 0 is already being read
          // during the start cycle and the address moves straight on to 1.
          if (start) begin
            state       <= LOAD_W;
            fc_r        <= frame_count;
            wcnt        <= '0;
            pcnt        <= '0;
            xcnt        <= '0;
            src_wt_addr <= 16'd1;
            src_px_addr <= '0;
          end
        end
        LOAD_W: begin
          if (wcnt < 32'(NUM_WT)) begin
            weight_wr_en   <= 1'b1;
            weight_wr_data <= src_wt_data;
            weight_wr_addr <= 32'(WT_BASE_ADDR) + wcnt;
            wcnt           <= wcnt + 32'd1;
          end else begin
            state <= (fc_r == 16'd0) ? FINISH : STREAM;
          end
          // Step through 1..NUM_WT-1, then park at 0 for the next run.
          if ((src_wt_addr != 16'd0) && (32'(src_wt_addr) < 32'(NUM_WT - 1)))
            src_wt_addr <= src_wt_addr + 16'd1;
          else
            src_wt_addr <= 16'd0;
        end
        STREAM: begin
          if (rd_issue) begin
            pcnt <= pcnt + 32'd1;
            // Stop on the last pixel address instead of running one past it.
            if (pcnt + 32'd1 < npx)
              src_px_addr <= src_px_addr + PX_AW'(1);
          end
          if (xfer) begin
            xcnt <= xcnt + 32'd1;
            if (xcnt == npx - 32'd1)
              state <= FINISH;
          end
        end
        FINISH: begin
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  conv_seq_prefetch #(
    .DW(8 * IN_CHANNEL)
  ) u_prefetch (
    .clk              (clk),
    .rst              (rst),
    .rd_allow         (rd_allow),
    .src_px_data      (src_px_data),
    .fifo_rd_en       (fifo_rd_en),
    .fifo_almost_full (fifo_almost_full),
    .rd_issue         (rd_issue),
    .xfer             (xfer),
    .o_data           (o_data),
    .o_valid          (o_valid)
  );

`ifdef CONV_SEQ_WT_CHECKSUM_EN
  logic [31:0] cks;

  always_ff @(posedge clk) begin
    if (rst)
      cks <= '0;
    else if ((state == IDLE) && start)
      cks <= '0;
    else if ((state == LOAD_W) && (wcnt < 32'(NUM_WT)))
      cks <= cks + src_wt_data;
  end

  assign wt_checksum = cks;
`else
  assign wt_checksum = '0;
`endif

endmodule

// File: tb/tb_conv_stream_sequencer.sv
module tb_conv_stream_sequencer;

  localparam int NUM_WT   = 40;
  localparam int FRAME_PX = 16;
  localparam int PXW      = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [15:0]     frame_count;
  logic            busy;
  logic            done;
  logic [15:0]     src_wt_addr;
  logic [31:0]     src_wt_data;
  logic [15:0]     src_px_addr;
  logic [PXW-1:0]  src_px_data;
  logic [31:0]     weight_wr_data;
  logic [31:0]     weight_wr_addr;
  logic            weight_wr_en;
  logic [PXW-1:0]  o_data;
  logic            o_valid;
  logic            fifo_rd_en;
  logic            fifo_almost_full;
  logic [31:0]     wt_checksum;
  logic [1:0]      dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  conv_stream_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .frame_count      (frame_count),
    .busy             (busy),
    .done             (done),
    .src_wt_addr      (src_wt_addr),
    .src_wt_data      (src_wt_data),
    .src_px_addr      (src_px_addr),
    .src_px_data      (src_px_data),
    .weight_wr_data   (weight_wr_data),
    .weight_wr_addr   (weight_wr_addr),
    .weight_wr_en     (weight_wr_en),
    .o_data           (o_data),
    .o_valid          (o_valid),
    .fifo_rd_en       (fifo_rd_en),
    .fifo_almost_full (fifo_almost_full),
    .wt_checksum      (wt_checksum),
    .dbg_state        (dbg_state)
  );

  // Source memories: synchronous read, one cycle of latency.
  logic [31:0]    wt_mem [0:63];
  logic [PXW-1:0] px_mem [0:255];
  int             cyc = 0;

  always @(posedge clk) begin
    src_wt_data <= wt_mem[src_wt_addr[5:0]];
    src_px_data <= px_mem[src_px_addr[7:0]];
    cyc         <= cyc + 1;
  end

  // scoreboard
  logic [63:0]    exp_wt_q[$];   // {weight_wr_addr, weight_wr_data}
  logic [PXW-1:0] exp_px_q[$];
  logic [31:0]    exp_cks;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ctrl"}, {58'd0, busy, done, weight_wr_en, o_valid, dbg_state}, 64'd0);
    check_eq({tag, "_addr"}, {16'd0, src_wt_addr, src_px_addr, o_data}, 64'd0);
    check_eq({tag, "_wr"}, {weight_wr_addr, weight_wr_data}, 64'd0);
    check_eq({tag, "_cks"}, {32'd0, wt_checksum}, 64'd0);
  endtask

  // per-job observations (relative cycle: start edge E is 0, first cycle after it is 1)
  int wr_n, ov_n, done_n, first_wr, last_wr, first_ov, last_ov, done_rel, busy_rel;
  int max_wt, max_px;

  // driver + monitor for one job. mode: 0 continuous grant, 1 five-cycle
  // almost_full burst mid-stream, 2 random grant. poke pulses start mid-stream,
  // rst_at > 0 asserts rst once rst_at pixels have been seen.
  task automatic run_job(input int fc, input int mode, input bit poke, input int rst_at);
    int  e, rel, bp_left;
    bit  seen_done, finished, prev_grant, bp_started, poke_done, rst_hit;
    exp_wt_q.delete();
    exp_px_q.delete();
    exp_cks = 32'd0;
    for (int i = 0; i < NUM_WT; i++) begin
      exp_wt_q.push_back({32'(i), wt_mem[i]});
      exp_cks = exp_cks + wt_mem[i];
    end
    for (int i = 0; i < fc * FRAME_PX; i++) exp_px_q.push_back(px_mem[i]);
    wr_n = 0; ov_n = 0; done_n = 0;
    first_wr = -1; last_wr = -1; first_ov = -1; last_ov = -1; done_rel = -1; busy_rel = -1;
    max_wt = 0; max_px = 0;
    seen_done = 0; finished = 0; bp_started = 0; bp_left = 0; poke_done = 0; rst_hit = 0;
    fifo_rd_en = 1'b1;
    fifo_almost_full = 1'b0;
    prev_grant = 1'b1;
    frame_count = 16'(fc);
    start = 1'b1;
    e = cyc + 1;
    for (int k = 0; k < 800 && !finished; k++) begin
      @(negedge clk);
      start = 1'b0;
      rel = cyc + 1 - e;
      if (rst_hit) begin
        rst = 1'b0;
        check_idle_outputs("rst_mid");
        finished = 1;
      end else begin
        if (busy && busy_rel < 0) busy_rel = rel;
        if (busy && int'(src_wt_addr) > max_wt) max_wt = int'(src_wt_addr);
        if (busy && int'(src_px_addr) > max_px) max_px = int'(src_px_addr);
        if (weight_wr_en) begin
          if (first_wr < 0) first_wr = rel;
          last_wr = rel;
          wr_n++;
          if (exp_wt_q.size() > 0) check_eq("wt_write", {weight_wr_addr, weight_wr_data}, exp_wt_q.pop_front());
          else check_eq("wt_extra_write", 64'd1, 64'd0);
        end
        if (o_valid) begin
          if (first_ov < 0) first_ov = rel;
          last_ov = rel;
          ov_n++;
          check_eq("ov_only_after_grant", {63'd0, prev_grant}, 64'd1);
          if (exp_px_q.size() > 0) check_eq("px_data", {48'd0, o_data}, {48'd0, exp_px_q.pop_front()});
          else check_eq("px_extra", 64'd1, 64'd0);
        end
        if (seen_done) begin
          check_eq("busy_after_done", {63'd0, busy}, 64'd0);
          check_eq("done_one_cycle", {63'd0, done}, 64'd0);
          finished = 1;
        end else if (done) begin
          done_n++;
          done_rel = rel;
          seen_done = 1;
          check_eq("busy_with_done", {63'd0, busy}, 64'd1);
        end
        case (mode)
          0: begin
            fifo_rd_en = 1'b1;
            fifo_almost_full = 1'b0;
          end
          1: begin
            fifo_rd_en = 1'b1;
            if (!bp_started && ov_n == 5) begin
              bp_started = 1;
              bp_left = 5;
            end
            fifo_almost_full = (bp_left > 0);
            if (bp_left > 0) bp_left--;
          end
          default: begin
            fifo_rd_en = ($urandom_range(0, 3) != 0);
            fifo_almost_full = ($urandom_range(0, 4) == 0);
          end
        endcase
        prev_grant = fifo_rd_en && !fifo_almost_full;
        if (poke && !poke_done && ov_n == 8) begin
          start = 1'b1;
          poke_done = 1;
        end
        if (rst_at > 0 && ov_n == rst_at) begin
          rst = 1'b1;
          rst_hit = 1;
        end
      end
    end
    if (!finished) check_eq("job_timeout", 64'd0, 64'd1);
  endtask

  // Post-job checks derived from the expected sequencing rules.
  task automatic job_checks(input int fc, input bit continuous);
    check_eq("busy_rise", 64'(busy_rel), 64'd1);
    check_eq("wr_count", 64'(wr_n), 64'(NUM_WT));
    check_eq("wr_first", 64'(first_wr), 64'd2);
    check_eq("wr_last", 64'(last_wr), 64'(NUM_WT + 1));
    check_eq("wt_addr_max", 64'(max_wt), 64'(NUM_WT - 1));
    check_eq("ov_count", 64'(ov_n), 64'(fc * FRAME_PX));
    check_eq("done_count", 64'(done_n), 64'd1);
    check_eq("wt_q_empty", 64'(exp_wt_q.size()), 64'd0);
    check_eq("px_q_empty", 64'(exp_px_q.size()), 64'd0);
`ifdef CONV_SEQ_WT_CHECKSUM_EN
    check_eq("wt_checksum", {32'd0, wt_checksum}, {32'd0, exp_cks});
`else
    check_eq("wt_checksum", {32'd0, wt_checksum}, 64'd0);
`endif
    if (fc == 0) begin
      check_eq("done_fc0", 64'(done_rel), 64'(NUM_WT + 3));
    end else begin
      check_eq("done_after_last_ov", 64'(done_rel), 64'(last_ov + 1));
      check_eq("px_addr_max", 64'(max_px), 64'(fc * FRAME_PX - 1));
      if (continuous) begin
        check_eq("ov_first", 64'(first_ov), 64'(NUM_WT + 4));
        check_eq("ov_contiguous", 64'(last_ov - first_ov), 64'(fc * FRAME_PX - 1));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    frame_count = 16'd0;
    fifo_rd_en = 1'b0;
    fifo_almost_full = 1'b0;
    for (int i = 0; i < 64; i++) wt_mem[i] = 32'(i * 3);
    for (int i = 0; i < 256; i++) px_mem[i] = {8'(i + 1), 8'(i + 1)};
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // weight load i*3 and one frame of {i+1, i+1} under continuous grant
    run_job(1, 0, 0, 0);
    job_checks(1, 1);
`ifdef CONV_SEQ_WT_CHECKSUM_EN
    check_eq("cks_2340", {32'd0, wt_checksum}, 64'd2340);
`endif

    // five cycles of almost_full mid-stream
    run_job(1, 1, 0, 0);
    job_checks(1, 0);

    // three frames of random pixels
    for (int i = 0; i < 256; i++) px_mem[i] = PXW'($urandom);
    run_job(3, 0, 0, 0);
    job_checks(3, 1);

    // zero frames
    run_job(0, 0, 0, 0);
    job_checks(0, 0);

    // start pulsed during STREAM is ignored
    run_job(1, 0, 1, 0);
    job_checks(1, 1);

    // random weights, random grant, two frames
    for (int i = 0; i < 64; i++) wt_mem[i] = $urandom;
    run_job(2, 2, 0, 0);
    job_checks(2, 0);

    // reset after pixel 7, then a full restart
    run_job(1, 0, 0, 7);
    check_eq("rst_px_seen", 64'(ov_n), 64'd7);
    check_eq("rst_no_done", 64'(done_n), 64'd0);
    run_job(1, 0, 0, 0);
    job_checks(1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
